// File: rtl/xbar_nxm_rr.sv
// xbar_nxm_rr: N-master x M-slave crossbar for the req/ack/resp bus.
//
// Each master request is routed to the slave selected by the top SEL_W address
// bits. Every slave port owns a round-robin arbiter and stays locked to its
// granted master until the write ack, or the read response, completes.
// A master with an outstanding read is held off every arbiter until its
// response has been delivered.
//
// Ports:
//   clk, rst                        clock (rising edge), synchronous active-high reset
//   m_req/m_addr/m_cmd/m_wdata      per-master request (cmd 0=read, 1=write)
//   m_ack/m_rdata/m_resp            per-master accept, read data, read data valid
//   s_req/s_addr/s_cmd/s_wdata      per-slave forwarded request
//   s_ack/s_rdata/s_resp            per-slave accept, read data, read data valid

// One slave port: round-robin arbiter plus IDLE/ADDR/RESP lock FSM.
module xbar_rr_port #(
   parameter int N_MASTERS = 4,
   parameter int MW        = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] cand,     // eligible masters for this slave
   input  logic [N_MASTERS-1:0] cmd,      // all master cmds, indexed by grant
   input  logic                 ack,
   input  logic                 resp,
   output logic [MW-1:0]        gnt,
   output logic                 in_addr,
   output logic                 in_resp
);
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2} state_t;

   state_t          state;
   logic [MW-1:0]   ptr;
   logic [MW-1:0]   win;
   logic            found;
   logic [MW:0]     idx;

   // First candidate at or after ptr, wrapping modulo N_MASTERS. One extra
   // bit on idx keeps ptr+k from overflowing before the wrap.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < N_MASTERS; k++) begin
         idx = {1'b0, ptr} + (MW+1)'(k);
         if (idx >= (MW+1)'(N_MASTERS)) idx = idx - (MW+1)'(N_MASTERS);
         if (!found && cand[idx[MW-1:0]]) begin
            found = 1'b1;
            win   = idx[MW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         gnt   <= '0;
      end else begin
         case (state)
            IDLE: if (found) begin
               gnt   <= win;
               state <= ADDR;
            end
            ADDR: if (ack) begin
               ptr   <= (gnt == MW'(N_MASTERS-1)) ? '0 : gnt + 1'b1;
               state <= cmd[gnt] ? IDLE : RESP;
            end
            RESP: if (resp) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign in_addr = (state == ADDR);
   assign in_resp = (state == RESP);
endmodule

module xbar_nxm_rr #(
   parameter int N_MASTERS = 4,
   parameter int N_SLAVES  = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int SEL_W     = $clog2(N_SLAVES)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_MASTERS-1:0]          m_req,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS-1:0]          m_cmd,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   output logic [N_MASTERS-1:0]          m_ack,
   output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
   output logic [N_MASTERS-1:0]          m_resp,
   output logic [N_SLAVES-1:0]           s_req,
   output logic [N_SLAVES*ADDR_W-1:0]    s_addr,
   output logic [N_SLAVES-1:0]           s_cmd,
   output logic [N_SLAVES*DATA_W-1:0]    s_wdata,
   input  logic [N_SLAVES-1:0]           s_ack,
   input  logic [N_SLAVES*DATA_W-1:0]    s_rdata,
   input  logic [N_SLAVES-1:0]           s_resp
);
   localparam int MW = $clog2(N_MASTERS);

   logic [N_MASTERS-1:0]                 pending;
   logic [N_SLAVES-1:0][N_MASTERS-1:0]   cand;
   logic [N_SLAVES-1:0][MW-1:0]          gnt;
   logic [N_SLAVES-1:0]                  in_addr;
   logic [N_SLAVES-1:0]                  in_resp;

   // A master competes only for its decoded slave, and not while a read of
   // its own is still waiting for the response.
   always_comb begin
      cand = '0;
      for (int j = 0; j < N_SLAVES; j++)
         for (int i = 0; i < N_MASTERS; i++)
            cand[j][i] = m_req[i] & ~pending[i] &
                         (m_addr[i*ADDR_W + ADDR_W - SEL_W +: SEL_W] == SEL_W'(j));
   end

   for (genvar j = 0; j < N_SLAVES; j++) begin : g_port
      xbar_rr_port #(
         .N_MASTERS (N_MASTERS),
         .MW        (MW)
      ) u_port (
         .clk     (clk),
         .rst     (rst),
         .cand    (cand[j]),
         .cmd     (m_cmd),
         .ack     (s_ack[j]),
         .resp    (s_resp[j]),
         .gnt     (gnt[j]),
         .in_addr (in_addr[j]),
         .in_resp (in_resp[j])
      );
   end

   // Slave side: forward the granted master only while in ADDR, else zeros.
   always_comb begin
      s_req   = in_addr;
      s_addr  = '0;
      s_cmd   = '0;
      s_wdata = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
         if (in_addr[j]) begin
            s_addr[j*ADDR_W +: ADDR_W]  = m_addr[int'(gnt[j])*ADDR_W +: ADDR_W];
            s_cmd[j]                    = m_cmd[gnt[j]];
            s_wdata[j*DATA_W +: DATA_W] = m_wdata[int'(gnt[j])*DATA_W +: DATA_W];
         end
      end
   end

   // Master side: ack passes through in ADDR, resp/rdata in RESP. A master
   // holds at most one grant, so the OR never merges two slaves.
   always_comb begin
      m_ack   = '0;
      m_resp  = '0;
      m_rdata = '0;
      for (int j = 0; j < N_SLAVES; j++) begin
         if (in_addr[j]) m_ack[gnt[j]] = m_ack[gnt[j]] | s_ack[j];
         if (in_resp[j]) begin
            m_resp[gnt[j]] = m_resp[gnt[j]] | s_resp[j];
            m_rdata[int'(gnt[j])*DATA_W +: DATA_W] =
               m_rdata[int'(gnt[j])*DATA_W +: DATA_W] | s_rdata[j*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending <= '0;
      end else begin
         for (int i = 0; i < N_MASTERS; i++) begin
            if (m_resp[i])                            pending[i] <= 1'b0;
            else if (m_req[i] & m_ack[i] & ~m_cmd[i]) pending[i] <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_xbar_nxm_rr.sv
// Scoreboard bench for xbar_nxm_rr (4x4, 32-bit). Stimulus pushes the
// expected slave-side handshake and master-side read data into queues; a
// separate monitor pops and compares whenever the DUT shows a handshake or
// a response.
module tb_xbar_nxm_rr;
   localparam int NM = 4;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic [NM-1:0]       m_req, m_cmd, m_ack, m_resp;
   logic [NM*AW-1:0]    m_addr;
   logic [NM*DW-1:0]    m_wdata, m_rdata;
   logic [NS-1:0]       s_req, s_cmd, s_ack, s_resp;
   logic [NS*AW-1:0]    s_addr;
   logic [NS*DW-1:0]    s_wdata, s_rdata;

   xbar_nxm_rr #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata), .m_resp(m_resp),
      .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
      .s_ack(s_ack), .s_rdata(s_rdata), .s_resp(s_resp)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; logic cmd; logic [31:0] wdata; } txn_t;
   typedef struct { int m; logic [31:0] addr; logic cmd; logic [31:0] wdata; } sexp_t;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   txn_t        mtx[NM][$];
   sexp_t       sq[NS][$];
   logic [31:0] mq[NM][$];
   int          hs_q0[$];
   bit          active[NM];
   int          req_cyc[NM], resp_cyc[NM];
   int          rise_cyc[NS], hs_cyc[NS];
   int          ack_dly[NS], resp_dly[NS], wcnt[NS], rcnt[NS];
   logic [31:0] sl_rdata[NS], rdat[NS];
   bit          rst_req = 1'b1;
   bit          keep_sl = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic issue(input int m, input logic [31:0] a, input logic c, input logic [31:0] d);
      txn_t  t;
      sexp_t e;
      int    s;
      s = int'(a[31:30]);
      t.addr = a; t.cmd = c; t.wdata = d;
      mtx[m].push_back(t);
      e.m = m; e.addr = a; e.cmd = c; e.wdata = d;
      sq[s].push_back(e);
      if (!c) mq[m].push_back(sl_rdata[s]);
   endtask

   // Master and slave behavioural models; inputs change 1 time unit after clk rises.
   initial begin : model
      txn_t t;
      rst = 1'b1; m_req = '0; m_addr = '0; m_cmd = '0; m_wdata = '0;
      s_ack = '0; s_resp = '0; s_rdata = '0;
      for (int j = 0; j < NS; j++) begin wcnt[j] = 0; rcnt[j] = 0; rdat[j] = '0; end
      for (int i = 0; i < NM; i++) active[i] = 1'b0;
      forever begin
         @(posedge clk); #1;
         rst = rst_req;
         for (int i = 0; i < NM; i++) begin
            if (rst_req) active[i] = 1'b0;
            if (!active[i] && !rst_req && mtx[i].size() > 0) begin
               t = mtx[i].pop_front();
               active[i] = 1'b1;
               m_req[i] = 1'b1; m_cmd[i] = t.cmd;
               m_addr[i*AW +: AW] = t.addr; m_wdata[i*DW +: DW] = t.wdata;
               req_cyc[i] = cyc;
            end else if (!active[i]) begin
               m_req[i] = 1'b0; m_cmd[i] = 1'b0;
               m_addr[i*AW +: AW] = '0; m_wdata[i*DW +: DW] = '0;
            end
         end
         for (int j = 0; j < NS; j++) begin
            if (rst_req) begin
               wcnt[j] = 0;
               if (!keep_sl) rcnt[j] = 0;
            end
            s_resp[j] = 1'b0;
            s_rdata[j*DW +: DW] = '0;
            if (rcnt[j] > 0) begin
               rcnt[j]--;
               if (rcnt[j] == 0) begin
                  s_resp[j] = 1'b1;
                  s_rdata[j*DW +: DW] = rdat[j];
               end
            end
            s_ack[j] = s_req[j] && (wcnt[j] >= ack_dly[j]);
         end
         @(negedge clk);
         for (int i = 0; i < NM; i++)
            if (m_req[i] && m_ack[i]) active[i] = 1'b0;
         for (int j = 0; j < NS; j++) begin
            if (s_req[j] && s_ack[j]) begin
               wcnt[j] = 0;
               if (!s_cmd[j]) begin rcnt[j] = resp_dly[j]; rdat[j] = sl_rdata[j]; end
            end else if (s_req[j]) begin
               wcnt[j]++;
            end
         end
      end
   end

   // Monitor: compares every slave handshake and master response to the queues.
   initial begin : monitor
      sexp_t         e;
      logic [31:0]   r;
      logic [NS-1:0] prev_sreq;
      prev_sreq = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            for (int j = 0; j < NS; j++) begin
               if (s_req[j] && !prev_sreq[j]) rise_cyc[j] = cyc;
               if (s_req[j] && s_ack[j]) begin
                  hs_cyc[j] = cyc;
                  if (j == 0) hs_q0.push_back(cyc);
                  if (sq[j].size() == 0) begin
                     chk($sformatf("spurious_hs_s%0d", j), 128'(s_addr[j*AW +: AW]), 128'(0));
                  end else begin
                     e = sq[j].pop_front();
                     chk($sformatf("s%0d_addr", j),  128'(s_addr[j*AW +: AW]),  128'(e.addr));
                     chk($sformatf("s%0d_cmd", j),   128'(s_cmd[j]),            128'(e.cmd));
                     chk($sformatf("s%0d_wdata", j), 128'(s_wdata[j*DW +: DW]), 128'(e.wdata));
                     chk($sformatf("s%0d_mack_m%0d", j, e.m), 128'(m_ack[e.m]), 128'(1));
                  end
               end
            end
            for (int i = 0; i < NM; i++) begin
               if (m_resp[i]) begin
                  resp_cyc[i] = cyc;
                  if (mq[i].size() == 0) begin
                     chk($sformatf("spurious_resp_m%0d", i), 128'(m_resp[i]), 128'(0));
                  end else begin
                     r = mq[i].pop_front();
                     chk($sformatf("m%0d_rdata", i), 128'(m_rdata[i*DW +: DW]), 128'(r));
                  end
               end
            end
         end
         prev_sreq = s_req;
      end
   end

   task automatic set_defaults();
      for (int j = 0; j < NS; j++) begin
         ack_dly[j] = 0; resp_dly[j] = 1; sl_rdata[j] = 32'h5100_0000 + j;
      end
   endtask

   // Reset for one cycle, then expect every output at zero.
   task automatic do_reset(input bit keep);
      set_defaults();
      for (int i = 0; i < NM; i++) begin mtx[i].delete(); mq[i].delete(); end
      for (int j = 0; j < NS; j++) sq[j].delete();
      hs_q0.delete();
      keep_sl = keep;
      rst_req = 1'b1;
      @(posedge clk);
      rst_req = 1'b0;
      @(negedge clk);
      chk("rst_s_req",   128'(s_req),   128'(0));
      chk("rst_s_addr",  128'(s_addr),  128'(0));
      chk("rst_s_cmd",   128'(s_cmd),   128'(0));
      chk("rst_s_wdata", 128'(s_wdata), 128'(0));
      chk("rst_m_ack",   128'(m_ack),   128'(0));
      chk("rst_m_resp",  128'(m_resp),  128'(0));
      chk("rst_m_rdata", 128'(m_rdata), 128'(0));
      keep_sl = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit busy;
      for (int n = 0; n < 300; n++) begin
         @(posedge clk);
         busy = 1'b0;
         for (int i = 0; i < NM; i++)
            if (active[i] || mtx[i].size() > 0 || mq[i].size() > 0) busy = 1'b1;
         for (int j = 0; j < NS; j++)
            if (sq[j].size() > 0 || rcnt[j] > 0) busy = 1'b1;
         if (!busy) return;
      end
      checks++; errors++;
      $display("FAIL timeout_%s: queues still busy after 300 cycles", nm);
   endtask

   initial begin : stim
      bit seen;
      set_defaults();
      do_reset(1'b0);

      // Single write, slave acks 2 cycles after s_req rises
      ack_dly[1] = 2;
      issue(0, 32'h4000_0010, 1'b1, 32'hA5A5_A5A5);
      wait_idle("write");
      chk("wr_sreq_latency", 128'(rise_cyc[1]), 128'(req_cyc[0] + 1));
      chk("wr_ack_delay",    128'(hs_cyc[1]),   128'(rise_cyc[1] + 2));

      // Single read, response 3 cycles after the handshake
      do_reset(1'b0);
      sl_rdata[3] = 32'h1234_5678; resp_dly[3] = 3;
      issue(2, 32'hC000_0000, 1'b0, 32'h0);
      wait_idle("read");
      chk("rd_resp_latency", 128'(resp_cyc[2]), 128'(hs_cyc[3] + 3));

      // Round robin: all four masters to slave 0, then M1 and M3
      do_reset(1'b0);
      for (int i = 0; i < NM; i++) issue(i, 32'h0000_0100 + 32'(i*4), 1'b1, 32'hB000_0000 + 32'(i));
      wait_idle("rr1");
      issue(1, 32'h0000_0200, 1'b1, 32'hB100_0001);
      issue(3, 32'h0000_0204, 1'b1, 32'hB100_0003);
      wait_idle("rr2");
      chk("rr_hs_count", 128'(hs_q0.size()), 128'(6));
      if (hs_q0.size() == 6) begin
         chk("rr_gap_01", 128'(hs_q0[1] - hs_q0[0]), 128'(2));
         chk("rr_gap_12", 128'(hs_q0[2] - hs_q0[1]), 128'(2));
         chk("rr_gap_23", 128'(hs_q0[3] - hs_q0[2]), 128'(2));
         chk("rr_gap_45", 128'(hs_q0[5] - hs_q0[4]), 128'(2));
      end

      // Parallel: M0->slave 0 and M1->slave 2, different ack delays
      do_reset(1'b0);
      ack_dly[2] = 3;
      issue(0, 32'h0000_0040, 1'b1, 32'h1111_0000);
      issue(1, 32'h8000_0040, 1'b1, 32'h2222_0000);
      wait_idle("par");
      chk("par_same_rise", 128'(rise_cyc[0]), 128'(rise_cyc[2]));
      chk("par_rise_lat",  128'(rise_cyc[2]), 128'(req_cyc[1] + 1));
      chk("par_ack_s0",    128'(hs_cyc[0]),   128'(rise_cyc[0]));
      chk("par_ack_s2",    128'(hs_cyc[2]),   128'(rise_cyc[2] + 3));

      // Pending mask: M0 read outstanding on slave 1 blocks its slave-2 write,
      // M1's slave-2 write goes first
      do_reset(1'b0);
      resp_dly[1] = 6; sl_rdata[1] = 32'hCAFE_0001;
      issue(0, 32'h4000_0000, 1'b0, 32'h0);
      issue(1, 32'h8000_0004, 1'b1, 32'h3333_0001);
      issue(0, 32'h8000_0008, 1'b1, 32'h3333_0000);
      wait_idle("pend");
      chk("pend_m0_after_resp", 128'(hs_cyc[2]), 128'(resp_cyc[0] + 2));

      // Reset while slave 1 is in RESP; its late resp must not reach M0
      do_reset(1'b0);
      resp_dly[1] = 5; sl_rdata[1] = 32'hDEAD_BEEF;
      issue(0, 32'h4000_0020, 1'b0, 32'h0);
      seen = 1'b0;
      for (int n = 0; n < 50 && !seen; n++) begin
         @(posedge clk);
         if (sq[1].size() == 0) seen = 1'b1;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL timeout_midrd_hs: no read handshake on slave 1");
      end
      do_reset(1'b1);
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (s_resp[1]) begin
            seen = 1'b1;
            chk("midrd_no_resp",  128'(m_resp),  128'(0));
            chk("midrd_no_rdata", 128'(m_rdata), 128'(0));
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL timeout_midrd_sresp: late slave resp never seen");
      end
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/xbar_nxm_rr.md
Name: xbar_nxm_rr

Overview:
- Parametrised N-master × M-slave crossbar for the master/slave req/ack/resp bus; successor to the fixed point-to-point master/slave link.
- Routes each master request to a slave selected by the address MSBs.
- Each slave port has its own round-robin arbiter. A slave stays locked to its granted master until the write ack, or until the read response, completes.
- Sits between the core masters and the memory/peripheral slaves.

Parameters:
- N_MASTERS, 4, number of master ports (≥2)
- N_SLAVES, 4, number of slave ports; must be a power of 2, ≥2
- ADDR_W, 32, address width
- DATA_W, 32, wdata/rdata width
- SEL_W, $clog2(N_SLAVES), slave-select field is addr[ADDR_W-1 -: SEL_W]

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- m_req  in  N_MASTERS  per-master request
- m_addr  in  N_MASTERS*ADDR_W  per-master address (master i at [i*ADDR_W +: ADDR_W])
- m_cmd  in  N_MASTERS  0=read, 1=write
- m_wdata  in  N_MASTERS*DATA_W  write data
- m_ack  out  N_MASTERS  request accepted
- m_rdata  out  N_MASTERS*DATA_W  read data
- m_resp  out  N_MASTERS  read data valid
- s_req  out  N_SLAVES  per-slave request
- s_addr  out  N_SLAVES*ADDR_W  forwarded address (full, unmodified)
- s_cmd  out  N_SLAVES  forwarded cmd
- s_wdata  out  N_SLAVES*DATA_W  forwarded wdata
- s_ack  in  N_SLAVES  slave accepted
- s_rdata  in  N_SLAVES*DATA_W  slave read data
- s_resp  in  N_SLAVES  slave read data valid

Behaviour:
- **Protocol (both sides).** req/addr/cmd/wdata are held stable until ack is sampled high; handshake occurs on the cycle req & ack. A read handshake is followed, ≥1 cycle later, by exactly one resp pulse carrying rdata. Writes have no resp.
- **Master pending flag.** Set on a master's read handshake; cleared on delivery of its resp. A master with pending=1 is masked from all arbiters; its req is not acked until the flag clears.
- **Per-slave FSM j, states IDLE / ADDR / RESP.**
  - IDLE: candidates = masters i with m_req[i], !pending[i], addr select field == j. If any candidate exists, the round-robin winner (first candidate at or after ptr_j, wrapping modulo N_MASTERS) is registered as gnt_j and the FSM goes to ADDR. Otherwise it stays in IDLE.
  - ADDR: s_req[j]=1. s_addr/s_cmd/s_wdata[j] are driven from master gnt_j. m_ack[gnt_j]=s_ack[j] (combinational pass-through). On the handshake, ptr_j ← gnt_j+1 (wrapping). A write then goes to IDLE; a read goes to RESP.
  - RESP: s_req[j]=0. m_resp[gnt_j]=s_resp[j] and m_rdata[gnt_j]=s_rdata[j] (combinational). On s_resp[j] the FSM goes to IDLE.
- **Latency.** Request to s_req is 1 cycle (registered grant). ack and resp add 0 cycles. Minimum back-to-back rate per slave is one transaction every 2 cycles (IDLE→ADDR).
- **Simultaneous events.** Multiple masters targeting one slave are serialised round-robin; masters targeting different slaves proceed in parallel. A master is only ever a candidate for its single decoded slave, so it holds at most one grant.
- **Outputs outside a grant.** s_addr/s_cmd/s_wdata for slaves not in ADDR are driven to 0. m_ack, m_resp and m_rdata are 0 for masters without an active ADDR/RESP routing.
- **Ignored inputs.** An s_ack[j] outside ADDR and an s_resp[j] outside RESP are ignored.
- **Reset.** All FSMs go to IDLE, ptr_j=0, gnt_j=0, pending=0. All outputs are 0 in the cycle after reset is sampled. Reset mid-transaction abandons it with no resp delivered; the external slaves must be reset together with the crossbar.

Test Plan:
- **Single write.** M0 writes addr 0x4000_0010 (slave 1), wdata 0xA5A5_A5A5; slave acks after 2 cycles → s_req[1] rises 1 cycle after m_req[0] with the same addr/wdata; m_ack[0] coincides with s_ack[1]; no m_resp.
- **Single read.** M2 reads slave 3 (addr 0xC000_0000); slave acks, then 3 cycles later resp with rdata 0x1234_5678 → m_resp[2]=1 with m_rdata=0x1234_5678 in the same cycle; all other m_resp=0.
- **Round-robin.** M0–M3 all hold write requests to slave 0 (zero-wait ack) → grant order 0,1,2,3. Then M1 and M3 re-request → order 1,3 (ptr wraps, starting from 0 → 1 first); the slave sees one handshake every 2 cycles.
- **Parallel.** M0→slave 0 and M1→slave 2 in the same cycle → both s_req asserted in the same next cycle, with independent acks.
- **Pending mask.** M0 read to slave 1 outstanding, and M0 issues a new req to slave 2 → s_req[2] stays 0 until the cycle after m_resp[0]; meanwhile M1's request to slave 2 is granted.
- **Reset mid-read.** Assert rst while slave 1 is in RESP → next cycle all outputs 0; a later s_resp[1] produces no m_resp.
